// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXIS streams onto one master port.
// A grant is taken in IDLE and held until the owner's tlast beat transfers downstream.
module axis_pkt_arbiter #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 64
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [NUM_PORTS-1:0]             s_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_tkeep,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    output logic [NUM_PORTS-1:0]             s_tready,

    output logic                             m_tvalid,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [KEEP_WIDTH-1:0]            m_tkeep,
    output logic [USER_WIDTH-1:0]            m_tuser,
    output logic                             m_tlast,
    input  logic                             m_tready,

    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy,
    output logic                             pkt_done
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   pkt_done_q, pkt_done_d;

    logic [NUM_PORTS-1:0]   hi_mask_c;
    logic [NUM_PORTS-1:0]   req_masked_c;
    logic [NUM_PORTS-1:0]   pick_c;
    logic [PTR_W-1:0]       gidx_c;
    logic                   tlast_xfer_c;

    // Isolate the lowest set bit of a request vector.
    function automatic logic [NUM_PORTS-1:0] lowest_one(input logic [NUM_PORTS-1:0] v);
        return v & (~v + ONE);
    endfunction

    // Requests strictly above rr_ptr take priority; otherwise wrap to the lowest index.
    always_comb begin
        hi_mask_c = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hi_mask_c[i] = (PTR_W'(i) > rr_ptr_q);
        end
        req_masked_c = s_tvalid & hi_mask_c;
        pick_c       = (|req_masked_c) ? lowest_one(req_masked_c) : lowest_one(s_tvalid);
    end

    always_comb begin
        gidx_c = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                gidx_c = PTR_W'(i);
            end
        end
    end

    // Output mux steered by the registered one-hot grant; all zero while idle.
    always_comb begin
        m_tdata = '0;
        m_tkeep = '0;
        m_tuser = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                m_tdata = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_tkeep = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                m_tuser = s_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
        m_tvalid     = |(s_tvalid & grant_q);
        m_tlast      = |(s_tlast & grant_q);
        s_tready     = grant_q & {NUM_PORTS{m_tready}};
        tlast_xfer_c = m_tvalid & m_tready & m_tlast;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        pkt_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|s_tvalid) begin
                    grant_d = pick_c;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tlast_xfer_c) begin
                    grant_d    = '0;
                    rr_ptr_d   = gidx_c;
                    pkt_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= PTR_RESET;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == ST_BUSY);
    assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: per-port beat queues feed a driver and a
// transaction-level reference model that predicts grant ownership and output beats.
module tb_axis_pkt_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      s_tvalid = '0;
    logic [N*DW-1:0]   s_tdata  = '0;
    logic [N*KW-1:0]   s_tkeep  = '0;
    logic [N*UW-1:0]   s_tuser  = '0;
    logic [N-1:0]      s_tlast  = '0;
    logic [N-1:0]      s_tready;
    logic              m_tvalid;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tlast;
    logic              m_tready = 1'b1;
    logic [N-1:0]      grant;
    logic              busy;
    logic              pkt_done;

    axis_pkt_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
        .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .busy(busy), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    beat_t src_q[N][$];
    beat_t exp_q[N][$];
    int    order_q[$];
    int    order_cyc[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pkt_id   = 0;
    bit mon_en   = 0;
    bit rand_valid = 0;
    bit rand_ready = 0;

    // Reference model state: current owner (-1 idle), last served port, pending pkt_done.
    int owner  = -1;
    int last_p = N - 1;
    bit done_m = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic add_pkt(input int p, input int len, input bit directed);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = directed ? 64'(64'hA0 + 64'(k))
                              : {8'(p), 16'(pkt_id), 8'(k), 32'($urandom)};
            b.keep = KW'($urandom);
            b.user = {32'($urandom), 32'($urandom)};
            b.last = (k == len - 1);
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
        pkt_id++;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        bit pending = 1;
        while (pending && n < budget) begin
            @(posedge clk); #2;
            n++;
            pending = (owner >= 0);
            for (int p = 0; p < N; p++) if (src_q[p].size() != 0) pending = 1;
        end
        checks++;
        if (pending) begin
            failures++;
            $display("FAIL drain_timeout actual=pending required=empty cycle=%0d", cyc);
        end
        for (int p = 0; p < N; p++) check("exp_q_empty", 64'(exp_q[p].size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Driver: retire accepted beats, then present each port's queue head.
    initial begin
        logic [N-1:0] acc;
        beat_t b;
        forever begin
            @(negedge clk);
            acc = s_tready & s_tvalid;
            @(posedge clk); #1;
            for (int p = 0; p < N; p++) begin
                if (acc[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
                if (src_q[p].size() != 0) begin
                    b = src_q[p][0];
                    s_tvalid[p] = !rand_valid || ($urandom_range(3) != 0);
                    s_tdata[p*DW +: DW] = b.data;
                    s_tkeep[p*KW +: KW] = b.keep;
                    s_tuser[p*UW +: UW] = b.user;
                    s_tlast[p] = b.last;
                end else begin
                    s_tvalid[p] = 1'b0;
                    s_tdata[p*DW +: DW] = '0;
                    s_tkeep[p*KW +: KW] = '0;
                    s_tuser[p*UW +: UW] = '0;
                    s_tlast[p] = 1'b0;
                end
            end
            m_tready = !rand_ready || ($urandom_range(9) < 7);
        end
    end

    // Monitor: compare DUT against the model, pop expected beats on transfers, advance model.
    initial begin
        logic [N-1:0] exp_grant;
        logic [N-1:0] prev_grant;
        beat_t b;
        bit xfer;
        bit found;
        int p;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                exp_grant = (owner >= 0) ? (N'(1) << owner) : '0;
                check("grant", 64'(grant), 64'(exp_grant));
                check("busy", 64'(busy), 64'(owner >= 0));
                check("pkt_done", 64'(pkt_done), 64'(done_m));
                check("s_tready", 64'(s_tready), 64'(m_tready ? exp_grant : '0));
                check("m_tvalid", 64'(m_tvalid), 64'((owner >= 0) && s_tvalid[owner]));
                if (owner < 0) check("m_tdata_idle", m_tdata, 64'd0);
                xfer = (owner >= 0) && s_tvalid[owner] && m_tready;
                b.last = 1'b0;
                if (xfer) begin
                    checks++;
                    if (exp_q[owner].size() == 0) begin
                        failures++;
                        $display("FAIL beat_underflow actual=transfer required=none port=%0d", owner);
                    end else begin
                        b = exp_q[owner].pop_front();
                        check("m_tdata", m_tdata, b.data);
                        check("m_tkeep", 64'(m_tkeep), 64'(b.keep));
                        check("m_tuser", m_tuser, b.user);
                        check("m_tlast", 64'(m_tlast), 64'(b.last));
                    end
                end
                if (grant != '0 && prev_grant == '0) begin
                    for (int i = 0; i < N; i++) if (grant[i]) order_q.push_back(i);
                    order_cyc.push_back(cyc);
                end
                prev_grant = grant;
                if (rst) begin
                    owner = -1; last_p = N - 1; done_m = 0;
                end else if (owner < 0) begin
                    done_m = 0;
                    found  = 0;
                    for (int k = 1; k <= N; k++) begin
                        p = (last_p + k) % N;
                        if (!found && s_tvalid[p]) begin
                            owner = p;
                            found = 1;
                        end
                    end
                end else begin
                    done_m = 0;
                    if (xfer && b.last) begin
                        last_p = owner; owner = -1; done_m = 1;
                    end
                end
            end
        end
    end

    initial begin
        // Reset held for two cycles, then idle with no requests.
        @(posedge clk); #1 mon_en = 1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Single 3-beat packet from port 2.
        #2 add_pkt(2, 3, 1);
        wait_drain(50);
        check("single_grant_port", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'd2);

        // All ports requesting 2-beat packets: rotation from port 0, 3-cycle period.
        pulse_reset();
        order_q.delete(); order_cyc.delete();
        @(posedge clk); #2;
        for (int r = 0; r < 2; r++) for (int q = 0; q < N; q++) add_pkt(q, 2, 0);
        wait_drain(100);
        for (int k = 0; k < 6; k++)
            check("rr_order", 64'(order_q.size() > k ? order_q[k] : -1), 64'(k % N));
        for (int k = 1; k < 6; k++)
            check("rr_period", 64'(order_cyc.size() > k ? order_cyc[k] - order_cyc[k-1] : -1), 64'd3);

        // Wrap after port 3: single-beat packets on ports 0 and 3.
        order_q.delete();
        @(posedge clk); #2;
        add_pkt(0, 1, 0); add_pkt(3, 1, 0);
        wait_drain(50);
        check("wrap_first", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'd0);
        check("wrap_second", 64'(order_q.size() > 1 ? order_q[1] : -1), 64'd3);

        // Reset during beat 2 of a 4-beat packet from port 1; port 0 then wins.
        order_q.delete();
        @(posedge clk); #2 add_pkt(1, 4, 0);
        for (int n = 0; n < 20 && owner != 1; n++) begin @(posedge clk); #2; end
        check("rst_mid_owner", 64'(owner), 64'd1);
        add_pkt(0, 1, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_drain(50);
        check("rst_mid_after_0", 64'(order_q.size() > 1 ? order_q[1] : -1), 64'd0);
        check("rst_mid_after_1", 64'(order_q.size() > 2 ? order_q[2] : -1), 64'd1);

        // Randomised traffic with valid gaps, backpressure and sporadic resets.
        rand_valid = 1; rand_ready = 1;
        for (int n = 0; n < 150; n++) begin
            add_pkt(int'($urandom_range(N - 1)), int'($urandom_range(5, 1)), 0);
            repeat ($urandom_range(6)) begin
                @(posedge clk); #1;
                if ($urandom_range(199) == 0) begin
                    rst = 1'b1;
                    @(posedge clk); #1 rst = 1'b0;
                end
            end
        end
        wait_drain(8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
